// File: rtl/sync_fifo_flags_if.sv
// ---------------------------------------------------------------------------
// sync_fifo_flags_if
// Bundles the producer/consumer handshake and status signals of
// sync_fifo_flags so that the FIFO and its users connect through one port.
//
// Parameters:
//   DATA_WIDTH  width of din/dout
//   ADDR_WIDTH  log2 of FIFO depth; count is ADDR_WIDTH+1 bits wide
//
// Signals:
//   wr_en, din          write request and data        (master -> slave)
//   rd_en               read request                  (master -> slave)
//   clr_err             clears overflow/underflow     (master -> slave)
//   dout                read data                     (slave -> master)
//   full, empty         occupancy extremes            (slave -> master)
//   almost_full/_empty  threshold flags               (slave -> master)
//   count               occupancy 0..DEPTH            (slave -> master)
//   overflow/underflow  sticky error flags            (slave -> master)
//
// Modports: master = the user of the FIFO, slave = the FIFO itself.
// ---------------------------------------------------------------------------
interface sync_fifo_flags_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4
);
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] din;
  logic                  rd_en;
  logic                  clr_err;
  logic [DATA_WIDTH-1:0] dout;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic [ADDR_WIDTH:0]   count;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output wr_en, din, rd_en, clr_err,
    input  dout, full, empty, almost_full, almost_empty, count,
           overflow, underflow
  );

  modport slave (
    input  wr_en, din, rd_en, clr_err,
    output dout, full, empty, almost_full, almost_empty, count,
           overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_flags.sv
// ---------------------------------------------------------------------------
// sync_fifo_flags
// Single-clock FIFO with occupancy count, programmable almost-full /
// almost-empty thresholds and sticky overflow/underflow flags.
//
// Ports:
//   clk      single clock, rising edge
//   rst_n    asynchronous active-low reset (memory contents are not reset)
//   fifo_if  sync_fifo_flags_if.slave: wr_en/din, rd_en, clr_err in;
//            dout, full, empty, almost_full, almost_empty, count,
//            overflow, underflow out
//
// Compile-time option:
//   SYNC_FIFO_FWFT_EN  defined   -> first-word-fall-through read port,
//                                   dout = head word while not empty, else 0
//                      undefined -> standard read port, dout registered and
//                                   updated on each accepted read (1 cycle)
// ---------------------------------------------------------------------------
module sync_fifo_flags #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDR_WIDTH    = 4,
  parameter int AFULL_THRESH  = (1 << ADDR_WIDTH) - 2,
  parameter int AEMPTY_THRESH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  sync_fifo_flags_if.slave fifo_if
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int PW    = ADDR_WIDTH + 1;

  localparam logic [PW-1:0] DEPTH_C  = PW'(DEPTH);
  localparam logic [PW-1:0] AFULL_C  = PW'(AFULL_THRESH);
  localparam logic [PW-1:0] AEMPTY_C = PW'(AEMPTY_THRESH);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  // Pointers carry one extra wrap bit so count = wr - rd distinguishes
  // full (DEPTH) from empty (0) without a separate flag.
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic          overflow_q, overflow_d;
  logic          underflow_q, underflow_d;

  logic [PW-1:0]         count_w;
  logic                  full_w;
  logic                  empty_w;
  logic                  wr_acc;
  logic                  rd_acc;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [ADDR_WIDTH-1:0] rd_addr;

  // Status decodes only from registered pointers, never from inputs.
  assign count_w = wr_ptr_q - rd_ptr_q;
  assign full_w  = (count_w == DEPTH_C);
  assign empty_w = (count_w == '0);

  assign wr_acc  = fifo_if.wr_en && !full_w;
  assign rd_acc  = fifo_if.rd_en && !empty_w;
  assign wr_addr = wr_ptr_q[ADDR_WIDTH-1:0];
  assign rd_addr = rd_ptr_q[ADDR_WIDTH-1:0];

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;

    if (wr_acc) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (rd_acc) rd_ptr_d = rd_ptr_q + PTR_ONE;

    // Clear first so a same-cycle error event overrides clr_err.
    if (fifo_if.clr_err) begin
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end
    if (fifo_if.wr_en && full_w)  overflow_d  = 1'b1;
    if (fifo_if.rd_en && empty_w) underflow_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage array is deliberately left out of reset so it maps to RAM.
  always_ff @(posedge clk) begin
    if (wr_acc) mem_q[wr_addr] <= fifo_if.din;
  end

`ifdef SYNC_FIFO_FWFT_EN
  // Head word is visible as soon as the pointers say it exists; a pop
  // moves rd_ptr and the next word appears in the same cycle.
  assign fifo_if.dout = empty_w ? '0 : mem_q[rd_addr];
`else
  logic [DATA_WIDTH-1:0] dout_q;

  // Write and read can never hit the same slot in one cycle: a read of the
  // slot being written would require empty, where the read is rejected.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_q <= '0;
    end else if (rd_acc) begin
      dout_q <= mem_q[rd_addr];
    end
  end

  assign fifo_if.dout = dout_q;
`endif

  assign fifo_if.count        = count_w;
  assign fifo_if.full         = full_w;
  assign fifo_if.empty        = empty_w;
  assign fifo_if.almost_full  = (count_w >= AFULL_C);
  assign fifo_if.almost_empty = (count_w <= AEMPTY_C);
  assign fifo_if.overflow     = overflow_q;
  assign fifo_if.underflow    = underflow_q;

endmodule

// File: tb/tb_sync_fifo_flags.sv
// ---------------------------------------------------------------------------
// tb_sync_fifo_flags
// Directed + short random test of sync_fifo_flags (DEPTH 16, AFULL 14,
// AEMPTY 2). Stimulus pushes every write it expects to be accepted into a
// scoreboard queue; a forked monitor pops and compares whenever the FIFO
// delivers a word. Works for both the standard and FWFT read port.
// ---------------------------------------------------------------------------
module tb_sync_fifo_flags;
  localparam int DW    = 32;
  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic clk;
  logic rst_n;

  sync_fifo_flags_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) fifo_if();

  sync_fifo_flags #(
    .DATA_WIDTH   (DW),
    .ADDR_WIDTH   (AW),
    .AFULL_THRESH (14),
    .AEMPTY_THRESH(2)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .fifo_if(fifo_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          total = 0;
  int          bad   = 0;
  int          mcount = 0;
  int          txn = 0;
  logic [31:0] exp_q[$];
  logic [31:0] hold_dout;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  task automatic compare_pop();
    logic [31:0] e;
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL rd_unexpected: got 0x%08h, want no data", fifo_if.dout);
    end else begin
      e = exp_q.pop_front();
      $display("rd   dout=0x%08h exp=0x%08h", fifo_if.dout, e);
      chk("rd_data", fifo_if.dout, e);
    end
  endtask

  // Monitor: FWFT data is checked in the cycle the pop is requested,
  // standard-mode data one cycle after the accepted read.
  task automatic monitor_loop();
    bit pend;
    pend = 1'b0;
    forever begin
      @(negedge clk);
`ifdef SYNC_FIFO_FWFT_EN
      if (rst_n && fifo_if.rd_en && !fifo_if.empty) compare_pop();
`else
      if (pend) compare_pop();
      pend = rst_n && fifo_if.rd_en && !fifo_if.empty;
`endif
    end
  endtask

  // One clock of stimulus. The expected-data queue and model count follow
  // the acceptance rules, independent of the DUT's own flags.
  task automatic step(input logic wr, input logic [31:0] d, input logic rd, input logic clr);
    bit wacc, racc;
    fifo_if.wr_en   = wr;
    fifo_if.din     = d;
    fifo_if.rd_en   = rd;
    fifo_if.clr_err = clr;
    wacc = wr && (mcount < DEPTH);
    racc = rd && (mcount > 0);
    if (wacc) exp_q.push_back(d);
    mcount = mcount + int'(wacc) - int'(racc);
    @(posedge clk);
    #1;
    txn++;
    $display("txn %0d wr=%0b din=0x%08h rd=%0b clr=%0b count=%0d",
             txn, wr, d, rd, clr, fifo_if.count);
    fifo_if.wr_en   = 1'b0;
    fifo_if.rd_en   = 1'b0;
    fifo_if.clr_err = 1'b0;
  endtask

  initial begin
    rst_n           = 1'b0;
    fifo_if.wr_en   = 1'b0;
    fifo_if.din     = '0;
    fifo_if.rd_en   = 1'b0;
    fifo_if.clr_err = 1'b0;

    fork
      monitor_loop();
    join_none

    // ---- reset ----
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    chk("rst_dout",   fifo_if.dout, 32'h0);
    chk("rst_count",  32'(fifo_if.count), 32'd0);
    chk("rst_empty",  32'(fifo_if.empty), 32'd1);
    chk("rst_aempty", 32'(fifo_if.almost_empty), 32'd1);
    chk("rst_full",   32'(fifo_if.full), 32'd0);
    chk("rst_afull",  32'(fifo_if.almost_full), 32'd0);
    chk("rst_ovf",    32'(fifo_if.overflow), 32'd0);
    chk("rst_unf",    32'(fifo_if.underflow), 32'd0);

    // ---- fill to full ----
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 32'h1A2B0000 + 32'(i), 1'b0, 1'b0);
      chk("fill_count",  32'(fifo_if.count), 32'(i + 1));
      chk("fill_aempty", 32'(fifo_if.almost_empty), 32'((i + 1) <= 2));
      chk("fill_afull",  32'(fifo_if.almost_full), 32'((i + 1) >= 14));
      chk("fill_full",   32'(fifo_if.full), 32'((i + 1) == 16));
    end
    step(1'b1, 32'hDEADBEEF, 1'b0, 1'b0);
    chk("ovf_count", 32'(fifo_if.count), 32'd16);
    chk("ovf_set",   32'(fifo_if.overflow), 32'd1);
    step(1'b0, 32'h0, 1'b0, 1'b1);
    chk("ovf_clr",   32'(fifo_if.overflow), 32'd0);

    // ---- drain ----
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 32'h0, 1'b1, 1'b0);
      chk("drain_count", 32'(fifo_if.count), 32'(15 - i));
    end
    chk("drain_full_after_first", 32'(fifo_if.full), 32'd0);
    step(1'b0, 32'h0, 1'b0, 1'b0);
    chk("drain_empty", 32'(fifo_if.empty), 32'd1);

    // ---- underflow and clear ----
`ifdef SYNC_FIFO_FWFT_EN
    hold_dout = 32'h0;
`else
    hold_dout = 32'h1A2B000F;
`endif
    step(1'b0, 32'h0, 1'b1, 1'b0);
    chk("unf_set",   32'(fifo_if.underflow), 32'd1);
    chk("unf_count", 32'(fifo_if.count), 32'd0);
    chk("unf_dout",  fifo_if.dout, hold_dout);
    step(1'b0, 32'h0, 1'b0, 1'b1);
    chk("unf_clr",   32'(fifo_if.underflow), 32'd0);
    step(1'b0, 32'h0, 1'b1, 1'b1);
    chk("unf_set_wins", 32'(fifo_if.underflow), 32'd1);
    step(1'b0, 32'h0, 1'b0, 1'b1);
    chk("unf_clr2",  32'(fifo_if.underflow), 32'd0);

    // ---- simultaneous access at count 8, pointers wrap past 31 ----
    for (int i = 0; i < 8; i++) step(1'b1, 32'h00000100 + 32'(i), 1'b0, 1'b0);
    chk("sim_pre_count", 32'(fifo_if.count), 32'd8);
    for (int i = 0; i < 40; i++) begin
      step(1'b1, 32'h00000200 + 32'(i), 1'b1, 1'b0);
      chk("sim_count", 32'(fifo_if.count), 32'd8);
    end
    for (int i = 0; i < 8; i++) step(1'b1, 32'h00000300 + 32'(i), 1'b0, 1'b0);
    chk("sim_full", 32'(fifo_if.full), 32'd1);
    step(1'b1, 32'hBAD0BAD0, 1'b1, 1'b0);
    chk("fullrw_count", 32'(fifo_if.count), 32'd15);
    chk("fullrw_ovf",   32'(fifo_if.overflow), 32'd1);
    chk("fullrw_full",  32'(fifo_if.full), 32'd0);
    for (int i = 0; i < 15; i++) step(1'b0, 32'h0, 1'b1, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b1);
    chk("fullrw_empty", 32'(fifo_if.empty), 32'd1);

    // ---- reset mid-stream ----
    for (int i = 0; i < 5; i++) step(1'b1, 32'h00000400 + 32'(i), 1'b0, 1'b0);
    chk("mid_pre_count", 32'(fifo_if.count), 32'd5);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_count", 32'(fifo_if.count), 32'd0);
    chk("mid_empty", 32'(fifo_if.empty), 32'd1);
    chk("mid_dout",  fifo_if.dout, 32'h0);
    rst_n = 1'b1;
    exp_q.delete();
    mcount = 0;
    step(1'b1, 32'h00000055, 1'b0, 1'b0);
    step(1'b1, 32'h00000066, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b0);
    chk("mid_drained", 32'(fifo_if.count), 32'd0);

    // ---- random smoke ----
    for (int i = 0; i < 64; i++) begin
      step(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)), 1'b0);
      chk("rand_count", 32'(fifo_if.count), 32'(mcount));
    end
    while (mcount > 0) step(1'b0, 32'h0, 1'b1, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b0);
    chk("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sync_fifo_flags.md
# sync_fifo_flags

Single-clock, parametrised FIFO with a level count, programmable almost-full and almost-empty thresholds, and sticky overflow/underflow error flags. It is the same-clock-domain successor to the dual-clock FIFO. It buffers data between producer and consumer stages that share one clock, and reports occupancy to flow-control logic without any synchroniser latency. The read interface is either standard (registered dout, one-cycle read latency) or first-word-fall-through, selected at compile time.

## Interface
- DATA_WIDTH, 32, width of din/dout
- ADDR_WIDTH, 4, log2 of depth; DEPTH = 2**ADDR_WIDTH
- AFULL_THRESH, DEPTH-2, almost_full asserts when count >= AFULL_THRESH; legal range 1..DEPTH
- AEMPTY_THRESH, 2, almost_empty asserts when count <= AEMPTY_THRESH; legal range 0..DEPTH-1, and must be < AFULL_THRESH
- clk  input  1  single clock; all logic on its rising edge
- rst_n  input  1  asynchronous active-low reset
- wr_en  input  1  write request
- din  input  DATA_WIDTH  write data
- rd_en  input  1  read request
- clr_err  input  1  one-cycle pulse that clears overflow/underflow
- dout  output  DATA_WIDTH  read data
- full  output  1  count == DEPTH
- empty  output  1  count == 0
- almost_full  output  1  count >= AFULL_THRESH
- almost_empty  output  1  count <= AEMPTY_THRESH
- count  output  ADDR_WIDTH+1  current occupancy, 0..DEPTH
- overflow  output  1  sticky: a write was attempted while full
- underflow  output  1  sticky: a read was attempted while empty

## Operation
- Storage: DEPTH x DATA_WIDTH array. Memory contents are not reset.
- Pointers: wr_ptr and rd_ptr, each ADDR_WIDTH+1 bits. The low ADDR_WIDTH bits address the array; pointers wrap naturally modulo 2*DEPTH.
- count = wr_ptr - rd_ptr, computed modulo 2**(ADDR_WIDTH+1). All flags decode from registered pointers/count only; no input-to-flag combinational path.
- Write accept: wr_acc = wr_en && !full. On an accepted write, mem[wr_ptr] <= din and wr_ptr++.
- Read accept: rd_acc = rd_en && !empty. On an accepted read, rd_ptr++.
- Simultaneous wr_acc and rd_acc: both pointers advance and count is unchanged.
- Full with wr_en and rd_en: the read is accepted and the write is rejected. No write-through. overflow sets.
- Empty with wr_en and rd_en: the write is accepted and the read is rejected. No bypass. underflow sets.
- overflow sets on any cycle with wr_en && full. underflow sets on any cycle with rd_en && empty. Both clear on clr_err. If a set and clr_err occur in the same cycle, set wins.
- A rejected access never changes pointers, memory, or dout.
- Reset values: dout 0, count 0, empty 1, full 0, almost_empty 1, almost_full 0, overflow 0, underflow 0, both pointers 0.
- Reset mid-operation: pointers and flags clear immediately (asynchronously). Buffered data is lost. The first write after release lands at address 0.

## Timing
- Write to visibility: after an accepted write at edge N, count, empty, and the almost flags reflect it after edge N.
- A read may be accepted at edge N+1 at the earliest.
- Standard mode: dout <= mem[rd_ptr] at the edge where rd_acc is true. dout is valid after that edge and held until the next accepted read. Read latency is 1 cycle.
- FWFT mode: see Configuration.
- full deasserts one cycle after the accepted read that frees a slot.
- Throughput: one write and one read per cycle sustained whenever 0 < count < DEPTH.

## Configuration
- Macro: SYNC_FIFO_FWFT_EN.
- Defined (first-word-fall-through):
  - dout = mem[rd_ptr] combinationally whenever !empty, and '0 while empty.
  - The head word is presented in the cycle after the write that made the FIFO non-empty.
  - rd_acc pops the head; the next word appears in the same cycle as the pointer update.
  - No dout register.
- Undefined (standard mode): registered dout as described in Timing. Memory read is synchronous.
- Flags, count, and error behaviour are identical in both modes.

## Test plan
Configuration for all scenarios: DATA_WIDTH=32, ADDR_WIDTH=4, AFULL_THRESH=14, AEMPTY_THRESH=2.

- Reset check: hold rst_n=0, then release. Required: dout=0, count=0, empty=1, almost_empty=1, full=0, almost_full=0, overflow=0, underflow=0.
- Fill to full and drain:
  - Write 0x1A2B0000..0x1A2B000F, one per cycle. Required: almost_empty drops at count=3, almost_full rises at count=14, full=1 at count=16.
  - A 17th write (0xDEADBEEF) is rejected and sets overflow=1.
  - Drain 16 reads. Required: exact order 0x1A2B0000..0x1A2B000F, with dout one cycle after rd_en (standard) or same cycle (FWFT). 0xDEADBEEF never appears.
- Underflow and clear:
  - rd_en=1 while empty. Required: underflow=1, pointers and dout unchanged.
  - Pulse clr_err. Required: underflow=0 the next cycle.
  - clr_err together with a new rd_en on empty. Required: underflow stays 1.
- Simultaneous access:
  - At count=8, assert wr_en and rd_en for 40 cycles with incrementing data. Required: count stays 8, zero mismatches, pointers wrap past 31 correctly.
  - At full, assert both. Required: read accepted, count=15, overflow=1.
- Reset mid-stream: after 5 writes, pulse rst_n low between edges. Required: count=0 and empty=1 immediately. The subsequent write of 0x00000055 is read back first.
- Random smoke: 64 transactions with randomized wr_en/rd_en against a scoreboard queue. Required: zero mismatches, and count always equals the queue size.
